// File: rtl/cfg_loader.sv
// cfg_loader: collects NUM_CELLS config words into a shadow bank, then commits
// the whole bank to config_sig on a single edge so cells never see a mix of
// old and new settings.
// Optional feature macro: CFG_LOADER_PARITY_EN (per-word odd parity, abort on error).
module cfg_loader #(
  parameter int NUM_CELLS  = 16,
  parameter int CFG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           in_ready,
  output logic [NUM_CELLS*CFG_WIDTH-1:0] config_sig,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int              IDX_W    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [IDX_W-1:0]               r_index;
  logic [CFG_WIDTH-1:0]           r_shadow [NUM_CELLS];
  logic [NUM_CELLS*CFG_WIDTH-1:0] r_config;
  logic                           r_done;
  logic                           w_accept;
  logic                           w_last;
  logic                           w_start_load;
  logic                           w_parity_bad;
  logic                           w_unused_data;

  assign w_accept     = in_valid & in_ready;
  assign w_last       = (r_index == LAST_IDX);
  assign w_start_load = (r_state == S_IDLE) && start;

`ifdef CFG_LOADER_PARITY_EN
  // The parity bit makes the XOR of bits [CFG_WIDTH:0] equal to 1.
  assign w_parity_bad  = ~(^in_data[CFG_WIDTH:0]);
  assign w_unused_data = ^{1'b0, in_data[DATA_WIDTH-1:CFG_WIDTH]};
`else
  assign w_parity_bad  = 1'b0;
  assign w_unused_data = ^in_data[DATA_WIDTH-1:CFG_WIDTH];
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: start opens a load, the last good word commits, a bad word aborts.
  always_comb begin
    // NOTE: default first, so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_LOAD;
      S_LOAD: begin
        if (w_accept) begin
          if (w_parity_bad) w_next_state = S_IDLE;
          else if (w_last)  w_next_state = S_COMMIT;
        end
      end
      S_COMMIT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output decode: words are taken only in LOAD; busy spans LOAD and COMMIT.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_COMMIT: busy = 1'b1;
      default: ;
    endcase
  end

  // Word index and shadow bank: each good word fills the next slot; the index parks on the last slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index <= '0;
      // NOTE: the shadow bank is cleared on reset so no stale slot survives a
      // reset; this keeps it in flops rather than a RAM macro.
      for (int k = 0; k < NUM_CELLS; k++) r_shadow[k] <= '0;
    end else if (w_start_load) begin
      r_index <= '0;
    end else if (w_accept && !w_parity_bad) begin
      r_shadow[r_index] <= in_data[CFG_WIDTH-1:0];
      if (!w_last) r_index <= r_index + 1'b1;
    end
  end

  // Commit: copy the whole bank at once and raise done for the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_config <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_COMMIT);
      if (r_state == S_COMMIT) begin
        for (int k = 0; k < NUM_CELLS; k++) r_config[k*CFG_WIDTH +: CFG_WIDTH] <= r_shadow[k];
      end
    end
  end

`ifdef CFG_LOADER_PARITY_EN
  logic r_err;

  // Sticky error: set by a bad-parity word, cleared only when a new load starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_err <= 1'b0;
    else if (w_start_load)             r_err <= 1'b0;
    else if (w_accept && w_parity_bad) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign config_sig = r_config;
  assign done       = r_done;

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 16, number of functional cells driven.
REQ-002 SHALL have parameter CFG_WIDTH, default 4, config bits per cell.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, input word width; DATA_WIDTH > CFG_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to begin a configuration load.
REQ-007 SHALL have port in_valid  input  1  in_data holds a config word.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  config word; bits [CFG_WIDTH-1:0] are the cell config.
REQ-009 SHALL have port in_ready  output  1  word accepted when in_valid & in_ready.
REQ-010 SHALL have port config_sig  output  NUM_CELLS*CFG_WIDTH  active config; cell k at bits [k*CFG_WIDTH +: CFG_WIDTH].
REQ-011 SHALL have port busy  output  1  high in LOAD and COMMIT.
REQ-012 SHALL have port done  output  1  one-cycle pulse on commit.
REQ-013 SHALL have port err  output  1  sticky load-error flag.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, COMMIT.
REQ-015 IDLE: in_ready=0; start=1 -> LOAD, word index cleared to 0, err cleared.
REQ-016 LOAD: in_ready=1; each accepted word writes in_data[CFG_WIDTH-1:0] into shadow slot[index], index increments by 1.
REQ-017 LOAD: acceptance of word NUM_CELLS-1 -> COMMIT next cycle; index does not wrap past NUM_CELLS-1.
REQ-018 COMMIT: in_ready=0; copies all shadow slots to config_sig in one edge, done=1 for exactly this cycle, -> IDLE.
REQ-019 Latency: last word accepted at edge t -> config_sig updated and done high in cycle after edge t+1.
REQ-020 config_sig SHALL hold its previous value during IDLE and LOAD; no partial update ever visible.
REQ-021 start SHALL be ignored in LOAD and COMMIT.
REQ-022 in_valid=0 in LOAD SHALL stall without state change; gaps of any length permitted.
REQ-023 in_data bits above CFG_WIDTH (except the parity bit, REQ-029) SHALL be ignored.
REQ-024 in_valid asserted in IDLE or COMMIT SHALL have no effect.

Reset
REQ-025 reset=1 SHALL asynchronously force state IDLE, index 0, all shadow slots 0, config_sig all 0, in_ready 0, busy 0, done 0, err 0.
REQ-026 reset asserted mid-LOAD SHALL discard the partial load; config_sig reads 0 immediately.
REQ-027 After reset deasserts, the block SHALL wait for start before accepting words.

Configuration
REQ-028 Macro CFG_LOADER_PARITY_EN SHALL select per-word parity checking.
REQ-029 With CFG_LOADER_PARITY_EN: in_data[CFG_WIDTH] is odd parity over in_data[CFG_WIDTH:0]; mismatch on an accepted word -> err=1, state -> IDLE next cycle, no commit, no done, config_sig unchanged.
REQ-030 Without CFG_LOADER_PARITY_EN: in_data[CFG_WIDTH] ignored, err tied to 0, no abort path.

Verification (NUM_CELLS=4, CFG_WIDTH=4)
REQ-031 Reset, start, words 0x1,0x2,0x3,0x9 back-to-back -> config_sig=0x9321, done one pulse one cycle after 4th accept, busy low afterward.
REQ-032 Load 0x5,0x5,0x5,0x5 with 3-cycle in_valid gaps; sample config_sig each cycle -> stays 0x0000 until commit, then 0x5555.
REQ-033 After 0x9321 loaded, start then two words, then assert reset -> config_sig=0x0000 immediately, next full load of 0x7,0x8,0x0,0x1 -> 0x1087.
REQ-034 start pulsed during LOAD, and in_valid held high in IDLE with 0xF -> no extra accept, in_ready=0 in IDLE, config_sig unchanged.
REQ-035 With CFG_LOADER_PARITY_EN, 2nd word 0x03 (bad parity) -> err=1, no done, config_sig keeps prior value; without macro same stimulus -> commit, err=0.
